// File: rtl/acc_isa_pkg.sv
// ISA constants, state encoding and EXEC strobe bundle for the accumulator processor control unit.
// Shared by the decoder and the FSM; holds no logic of its own.
package acc_isa_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JC  = 4'hD;
    localparam logic [3:0] OP_LDI = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MDR = 2'd1;
    localparam logic [1:0] SRC_IMM = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_OPERAND = 3'd3,
        ST_MEM     = 3'd4,
        ST_EXEC    = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    typedef struct packed {
        logic       acc_load;
        logic       flags_load;
        logic       pc_load;
        logic [1:0] acc_src;
        logic [3:0] alu_op;
    } exec_t;

    // Opcodes followed by an address or immediate byte.
    function automatic logic is_two_byte(input logic [3:0] op);
        return ((op >= OP_LDA) && (op <= OP_XOR)) || ((op >= OP_JMP) && (op <= OP_LDI));
    endfunction

endpackage

// File: rtl/acc_ctrl_decode.sv
// Opcode decoder: successor states after DECODE/OPERAND/MEM and the EXEC strobe set.
// Purely combinational; zero latency, no flow control.
module acc_ctrl_decode
    import acc_isa_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       zero_flag,
    input  logic       carry_flag,
    output state_t     dec_next,
    output state_t     oper_next,
    output logic       is_store,
    output exec_t      exec_dec
);

    always_comb begin
        dec_next = ST_EXEC;
        if (opcode == OP_NOP) begin
            dec_next = ST_FETCH;
        end else if (opcode == OP_HLT) begin
            dec_next = ST_HALT;
        end else if (is_two_byte(opcode)) begin
            dec_next = ST_OPERAND;
        end

        // Memory-referencing opcodes need the data phase; jumps and LDI use MAR directly.
        oper_next = (opcode <= OP_XOR) ? ST_MEM : ST_EXEC;
        is_store  = (opcode == OP_STA);

        exec_dec = '0;
        case (opcode)
            OP_LDA: begin
                exec_dec.acc_load = 1'b1;
                exec_dec.acc_src  = SRC_MDR;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
                exec_dec.acc_load   = 1'b1;
                exec_dec.flags_load = 1'b1;
                exec_dec.acc_src    = SRC_ALU;
                exec_dec.alu_op     = opcode;
            end
            OP_LDI: begin
                exec_dec.acc_load = 1'b1;
                exec_dec.acc_src  = SRC_IMM;
            end
            OP_JMP:  exec_dec.pc_load = 1'b1;
            OP_JZ:   exec_dec.pc_load = zero_flag;
            OP_JC:   exec_dec.pc_load = carry_flag;
            default: exec_dec = '0;
        endcase
    end

endmodule

// File: rtl/acc_ctrl_fsm.sv
// Multi-cycle controller for the 8-bit accumulator CPU: fetch, operand, memory and execute phases.
// 2-5 cycles per instruction plus one per memory wait cycle; requests hold until mem_ack or timeout.
module acc_ctrl_fsm
    import acc_isa_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    input  logic       zero_flag,
    input  logic       carry_flag,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_load,
    output logic       mdr_load,
    output logic       acc_load,
    output logic       flags_load,
    output logic [1:0] acc_src,
    output logic [3:0] alu_op,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state
);

    localparam logic [7:0] WAIT_LIM8 = 8'(WAIT_LIMIT);

    state_t     cur_st;
    state_t     nxt_st;
    logic [7:0] ir;
    logic [7:0] wait_cnt;
    logic       requesting;
    logic       timeout;
    state_t     dec_next;
    state_t     oper_next;
    logic       is_store;
    exec_t      exec_dec;
    logic       unused_ir_lo;

    // The low nibble of the instruction byte carries no meaning in this ISA.
    assign unused_ir_lo = ^ir[3:0];

    acc_ctrl_decode u_decode (
        .opcode     (ir[7:4]),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .dec_next   (dec_next),
        .oper_next  (oper_next),
        .is_store   (is_store),
        .exec_dec   (exec_dec)
    );

    assign requesting = (cur_st == ST_FETCH) || (cur_st == ST_OPERAND) || (cur_st == ST_MEM);
    assign timeout    = (WAIT_LIMIT != 0) && requesting && !mem_ack
                        && (wait_cnt == WAIT_LIM8 - 8'd1);

    // Ack-qualified strobes must land in the same cycle the memory returns data.
    assign pc_inc   = mem_ack && ((cur_st == ST_FETCH) || (cur_st == ST_OPERAND));
    assign mar_load = mem_ack && (cur_st == ST_OPERAND);
    assign mdr_load = mem_ack && (cur_st == ST_MEM) && !is_store;
    assign state    = cur_st;

    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            ST_IDLE:    nxt_st = ST_FETCH;
            ST_FETCH:   if (mem_ack) nxt_st = ST_DECODE;
            ST_DECODE:  nxt_st = dec_next;
            ST_OPERAND: if (mem_ack) nxt_st = oper_next;
            ST_MEM:     if (mem_ack) nxt_st = is_store ? ST_FETCH : ST_EXEC;
            ST_EXEC:    nxt_st = ST_FETCH;
            ST_HALT:    nxt_st = ST_HALT;
            default:    nxt_st = ST_IDLE;
        endcase
        if (timeout) begin
            nxt_st = ST_HALT;
        end
    end

    // Moore outputs are registered from the next state so they are valid for the whole state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_st     <= ST_IDLE;
            ir         <= 8'd0;
            wait_cnt   <= 8'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            addr_sel   <= 1'b0;
            pc_load    <= 1'b0;
            acc_load   <= 1'b0;
            flags_load <= 1'b0;
            acc_src    <= 2'd0;
            alu_op     <= 4'd0;
            halted     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            cur_st <= nxt_st;

            if ((cur_st == ST_FETCH) && mem_ack) begin
                ir <= mem_rdata;
            end

            if (requesting) begin
                wait_cnt <= mem_ack ? 8'd0 : wait_cnt + 8'd1;
            end

            mem_req  <= (nxt_st == ST_FETCH) || (nxt_st == ST_OPERAND) || (nxt_st == ST_MEM);
            addr_sel <= (nxt_st == ST_MEM);
            mem_we   <= (nxt_st == ST_MEM) && is_store;

            if (nxt_st == ST_EXEC) begin
                pc_load    <= exec_dec.pc_load;
                acc_load   <= exec_dec.acc_load;
                flags_load <= exec_dec.flags_load;
                acc_src    <= exec_dec.acc_src;
                alu_op     <= exec_dec.alu_op;
            end else begin
                pc_load    <= 1'b0;
                acc_load   <= 1'b0;
                flags_load <= 1'b0;
                acc_src    <= 2'd0;
                alu_op     <= 4'd0;
            end

            halted <= (nxt_st == ST_HALT);
            if (timeout) begin
                fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_acc_ctrl_fsm.sv
// Directed bench for acc_ctrl_fsm: program flow, memory waits, branches, halt, timeout and async reset.
module tb_acc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_ack = 1'b0;
    logic       zero_flag = 1'b0;
    logic       carry_flag = 1'b0;
    logic       ack_t = 1'b0;

    logic       mem_req, mem_we, addr_sel, pc_inc, pc_load, mar_load, mdr_load;
    logic       acc_load, flags_load, halted, fault;
    logic [1:0] acc_src;
    logic [3:0] alu_op;
    logic [2:0] state;

    logic       mem_req_t, halted_t, fault_t;
    logic [2:0] state_t;
    logic       unused_we_t, unused_asel_t, unused_inc_t, unused_pcl_t, unused_mar_t, unused_mdr_t;
    logic       unused_accl_t, unused_fl_t;
    logic [1:0] unused_src_t;
    logic [3:0] unused_alu_t;

    int checks = 0;
    int errors = 0;

    acc_ctrl_fsm dut (
        .clk(clk), .rstn(rstn), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .pc_inc(pc_inc),
        .pc_load(pc_load), .mar_load(mar_load), .mdr_load(mdr_load), .acc_load(acc_load),
        .flags_load(flags_load), .acc_src(acc_src), .alu_op(alu_op),
        .halted(halted), .fault(fault), .state(state)
    );

    acc_ctrl_fsm #(.WAIT_LIMIT(4)) dut_to (
        .clk(clk), .rstn(rstn), .mem_rdata(mem_rdata), .mem_ack(ack_t),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .mem_req(mem_req_t), .mem_we(unused_we_t), .addr_sel(unused_asel_t), .pc_inc(unused_inc_t),
        .pc_load(unused_pcl_t), .mar_load(unused_mar_t), .mdr_load(unused_mdr_t),
        .acc_load(unused_accl_t), .flags_load(unused_fl_t), .acc_src(unused_src_t),
        .alu_op(unused_alu_t), .halted(halted_t), .fault(fault_t), .state(state_t)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [2:0] st, input logic req,
                           input logic we, input logic asel);
        chk({tag, ".state"}, 8'(state), 8'(st));
        chk({tag, ".req"}, 8'(mem_req), 8'(req));
        chk({tag, ".we"}, 8'(mem_we), 8'(we));
        chk({tag, ".asel"}, 8'(addr_sel), 8'(asel));
    endtask

    task automatic chk_ack(input string tag, input logic inc, input logic mar, input logic mdr);
        chk({tag, ".pc_inc"}, 8'(pc_inc), 8'(inc));
        chk({tag, ".mar_load"}, 8'(mar_load), 8'(mar));
        chk({tag, ".mdr_load"}, 8'(mdr_load), 8'(mdr));
    endtask

    task automatic chk_exec(input string tag, input logic accl, input logic [1:0] src,
                            input logic fl, input logic pcl, input logic [3:0] alu);
        chk({tag, ".acc_load"}, 8'(acc_load), 8'(accl));
        chk({tag, ".acc_src"}, 8'(acc_src), 8'(src));
        chk({tag, ".flags_load"}, 8'(flags_load), 8'(fl));
        chk({tag, ".pc_load"}, 8'(pc_load), 8'(pcl));
        chk({tag, ".alu_op"}, 8'(alu_op), 8'(alu));
    endtask

    // Advance to just after the next rising edge; ack is a one-cycle pulse unless re-driven.
    task automatic tick();
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
    endtask

    task automatic ack(input logic [7:0] d);
        mem_ack   = 1'b1;
        mem_rdata = d;
        #1;
    endtask

    // Entered in a FETCH cycle; leaves in the following FETCH cycle (4 cycles).
    task automatic run_branch(input string tag, input logic [7:0] opb, input logic exp_pc);
        chk_bus({tag, ".f"}, 3'd1, 1'b1, 1'b0, 1'b0);
        ack(opb);
        tick();
        chk_bus({tag, ".d"}, 3'd2, 1'b0, 1'b0, 1'b0);
        tick();
        chk_bus({tag, ".o"}, 3'd3, 1'b1, 1'b0, 1'b0);
        ack(8'h40);
        chk_ack({tag, ".o"}, 1'b1, 1'b1, 1'b0);
        tick();
        chk_bus({tag, ".e"}, 3'd5, 1'b0, 1'b0, 1'b0);
        chk_exec({tag, ".e"}, 1'b0, 2'd0, 1'b0, exp_pc, 4'd0);
        tick();
        chk({tag, ".next"}, 8'(state), 8'd1);
    endtask

    initial begin
        rstn = 1'b1;
        #2;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_bus("rst", 3'd0, 1'b0, 1'b0, 1'b0);
        chk_ack("rst", 1'b0, 1'b0, 1'b0);
        chk_exec("rst", 1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
        chk("rst.halted", 8'(halted), 8'd0);
        chk("rst.fault", 8'(fault), 8'd0);

        // LDI 0x05
        rstn = 1'b1;
        #1;
        chk_bus("idle", 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_bus("ldi.f", 3'd1, 1'b1, 1'b0, 1'b0);
        ack(8'hE5);
        chk_ack("ldi.f", 1'b1, 1'b0, 1'b0);
        tick();
        chk_bus("ldi.d", 3'd2, 1'b0, 1'b0, 1'b0);
        chk_exec("ldi.d", 1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
        tick();
        chk_bus("ldi.o", 3'd3, 1'b1, 1'b0, 1'b0);
        ack(8'h05);
        chk_ack("ldi.o", 1'b1, 1'b1, 1'b0);
        tick();
        chk_bus("ldi.e", 3'd5, 1'b0, 1'b0, 1'b0);
        chk_exec("ldi.e", 1'b1, 2'd2, 1'b0, 1'b0, 4'd0);

        // ADD [0x20], memory returns 0x07
        tick();
        chk_bus("add.f", 3'd1, 1'b1, 1'b0, 1'b0);
        ack(8'h30);
        chk_ack("add.f", 1'b1, 1'b0, 1'b0);
        tick();
        chk_bus("add.d", 3'd2, 1'b0, 1'b0, 1'b0);
        tick();
        chk_bus("add.o", 3'd3, 1'b1, 1'b0, 1'b0);
        ack(8'h20);
        chk_ack("add.o", 1'b1, 1'b1, 1'b0);
        tick();
        chk_bus("add.m", 3'd4, 1'b1, 1'b0, 1'b1);
        ack(8'h07);
        chk_ack("add.m", 1'b0, 1'b0, 1'b1);
        tick();
        chk_bus("add.e", 3'd5, 1'b0, 1'b0, 1'b0);
        chk_exec("add.e", 1'b1, 2'd0, 1'b1, 1'b0, 4'd3);

        // STA [0x80] with three wait cycles in MEM
        tick();
        ack(8'h20);
        tick();
        chk_bus("sta.d", 3'd2, 1'b0, 1'b0, 1'b0);
        tick();
        ack(8'h80);
        chk_ack("sta.o", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk_bus("sta.wait", 3'd4, 1'b1, 1'b1, 1'b1);
            chk_ack("sta.wait", 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk_bus("sta.ackcyc", 3'd4, 1'b1, 1'b1, 1'b1);
        ack(8'h00);
        chk_ack("sta.ackcyc", 1'b0, 1'b0, 1'b0);
        tick();
        chk_bus("sta.next", 3'd1, 1'b1, 1'b0, 1'b0);
        chk_exec("sta.next", 1'b0, 2'd0, 1'b0, 1'b0, 4'd0);

        // Branches
        zero_flag = 1'b1;
        run_branch("jz.taken", 8'hC0, 1'b1);
        zero_flag = 1'b0;
        carry_flag = 1'b1;
        run_branch("jz.not", 8'hC0, 1'b0);
        run_branch("jc.taken", 8'hD0, 1'b1);
        carry_flag = 1'b0;
        zero_flag = 1'b1;
        run_branch("jc.not", 8'hD0, 1'b0);
        zero_flag = 1'b0;
        run_branch("jmp", 8'hB0, 1'b1);

        // HLT
        ack(8'hF0);
        chk_ack("hlt.f", 1'b1, 1'b0, 1'b0);
        tick();
        chk_bus("hlt.d", 3'd2, 1'b0, 1'b0, 1'b0);
        chk("hlt.d.halted", 8'(halted), 8'd0);
        tick();
        chk_bus("hlt.h", 3'd6, 1'b0, 1'b0, 1'b0);
        chk("hlt.h.halted", 8'(halted), 8'd1);
        for (int i = 0; i < 22; i++) begin
            tick();
            mem_ack = (i % 2 == 0);
            mem_rdata = 8'h10;
            #1;
            chk_bus("hlt.stay", 3'd6, 1'b0, 1'b0, 1'b0);
            chk_ack("hlt.stay", 1'b0, 1'b0, 1'b0);
            chk("hlt.stay.halted", 8'(halted), 8'd1);
            chk("hlt.stay.fault", 8'(fault), 8'd0);
        end

        // Reset during an LDA memory phase
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        chk("rst2.state", 8'(state), 8'd0);
        chk("rst2.halted", 8'(halted), 8'd0);
        tick();
        ack(8'h10);
        tick();
        tick();
        ack(8'h33);
        tick();
        chk_bus("lda.m", 3'd4, 1'b1, 1'b0, 1'b1);
        #2;
        mem_ack = 1'b1;
        rstn = 1'b0;
        #1;
        chk_bus("rst.mid", 3'd0, 1'b0, 1'b0, 1'b0);
        chk_ack("rst.mid", 1'b0, 1'b0, 1'b0);
        chk_exec("rst.mid", 1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
        tick();
        rstn = 1'b1;
        #1;
        chk("rel.state", 8'(state), 8'd0);
        chk("rel.to.state", 8'(state_t), 8'd0);
        chk("rel.to.fault", 8'(fault_t), 8'd0);

        // Neither instance is acked from here: only the WAIT_LIMIT=4 one gives up.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to.req", 8'(mem_req_t), 8'd1);
            chk("to.state", 8'(state_t), 8'd1);
            chk("to.halted", 8'(halted_t), 8'd0);
            chk("to.fault", 8'(fault_t), 8'd0);
            chk_bus("nolimit.wait", 3'd1, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to.h.req", 8'(mem_req_t), 8'd0);
            chk("to.h.state", 8'(state_t), 8'd6);
            chk("to.h.halted", 8'(halted_t), 8'd1);
            chk("to.h.fault", 8'(fault_t), 8'd1);
            chk_bus("nolimit.still", 3'd1, 1'b1, 1'b0, 1'b0);
            chk("nolimit.fault", 8'(fault), 8'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
